intersection_phase_sched: RTL and testbench
===========================================

// Module: intersection_phase_sched
// PURPOSE
//   Phase scheduler for a two-road (NS/EW) intersection. It sequences green -> yellow -> all-red per
//   direction and generates the w/tranzit/enable controls for the per-direction light controllers
//   (2-bit light code 00 red, 01 yellow, 10 green, 11 all-red).
//   Car-sensor requests are latched and arbitrated. A maintenance input forces all-red.
// PARAMETERS
//   T_GREEN_MIN  3   ticks a green phase lasts before it may yield to a pending opposing request
//   T_GREEN_MAX  8   ticks after which green yields even if its own direction still has demand
//   T_YELLOW     2   ticks of yellow
//   T_ALLRED     1   ticks of all-red clearance between directions
//   CW           4   timer width; must satisfy 2**CW > max(all T_*)
// PORTS
//   clk_i         in   1  clock
//   rst_i         in   1  synchronous reset, active high
//   tick_i        in   1  one-cycle timebase strobe (e.g. 1 Hz); all durations counted in ticks
//   req_ns_i      in   1  NS car-sensor demand (level)
//   req_ew_i      in   1  EW car-sensor demand (level)
//   maint_i       in   1  maintenance: force all-red while high
//   w_ns_o        out  2  light code for NS controller
//   tranzit_ns_o  out  1  NS yellow-transit flag
//   w_ew_o        out  2  light code for EW controller
//   tranzit_ew_o  out  1  EW yellow-transit flag
//   en_o          out  1  one-cycle load strobe to both controllers on every phase change
//   phase_o       out  3  current state encoding (debug/status)
// BEHAVIOUR
//   - Single clock clk_i; reset is synchronous and active-high on rst_i. All outputs are registered.
//   - Reset values: state=ALLRED_INIT, timer=0, pend_ns=pend_ew=0.
//     w_ns_o=w_ew_o=2'b11, tranzit_*=0, phase_o=0.
//     en_o=1 in the first cycle after reset deasserts; this loads all-red into the controllers.
//   - States: ALLRED_INIT(0) NS_GREEN(1) NS_YELLOW(2) ALLRED_A(3) EW_GREEN(4) EW_YELLOW(5) ALLRED_B(6) MAINT(7).
//   - Timer: cleared on state entry; increments on tick_i, saturating at 2**CW-1.
//     A duration T elapses on the tick_i cycle where timer==T-1. The transition is taken in that same cycle.
//     New outputs and the en_o pulse appear on the next clk_i edge, giving 1 cycle latency from the deciding tick.
//   - Pending bits: pend_x is set while req_x_i=1. pend_x is cleared in the cycle the scheduler enters X_GREEN.
//     If req_x_i is still high in that cycle, set wins: pend_x stays 1.
//   - Transitions:
//     ALLRED_INIT -> NS_GREEN after T_ALLRED.
//     NS_GREEN -> NS_YELLOW when pend_ew and one of:
//       (timer>=T_GREEN_MIN-1 and req_ns_i=0), or
//       timer==T_GREEN_MAX-1,
//       evaluated on tick_i.
//     NS_GREEN with pend_ew=0: rest in green indefinitely; the timer saturates.
//     NS_YELLOW -> ALLRED_A after T_YELLOW.
//     ALLRED_A -> EW_GREEN after T_ALLRED.
//     EW side mirrors: EW_GREEN -> EW_YELLOW -> ALLRED_B -> NS_GREEN.
//   - Output mapping: x_GREEN gives w_x=10. x_YELLOW gives w_x=01 and tranzit_x=1. The opposing direction is 00.
//     ALLRED_* gives both directions 00. MAINT and ALLRED_INIT give both directions 11.
//   - maint_i=1 in any state: next state MAINT; takes priority over timer transitions.
//     When maint_i falls: MAINT -> ALLRED_INIT. Pending bits are kept across MAINT.
//   - rst_i mid-phase: returns to reset values on the next edge, regardless of tick_i/maint_i.
//   - Invariant: both directions never non-red simultaneously.
//     A direction never goes green->red without a yellow phase, except when forced by MAINT or reset.
//   - tick_i and a phase change in the same cycle: the timer counts the tick only in the old state,
//     then clears to 0 in the new state.
// STRUCTURE
//   - Shared header intersection_pkg.vh holds:
//     light codes LIGHT_RED/YELLOW/GREEN/ALLRED; state localparams ST_*; default timing constants.
//   - Sub-module phase_timer holds the clear/tick/saturate counter and the compare against a selected duration.
//     The FSM, pending latches and output registers are in this module.
// TESTING  (T_GREEN_MIN=3, T_GREEN_MAX=6, T_YELLOW=2, T_ALLRED=1, tick every 4 clk)
//   - Reset, no requests -> 11/11 with en_o pulse; NS_GREEN (w_ns=10, w_ew=00) after 1 tick; stays green 20 ticks; en_o pulses only at phase changes.
//   - req_ew_i pulse 1 clk at tick 5 of NS_GREEN, req_ns_i=0 -> NS_YELLOW on that tick (tranzit_ns=1, 2 ticks) -> ALLRED_A 1 tick -> EW_GREEN; pend_ew cleared.
//   - req_ns_i held high and req_ew_i high from green entry -> NS green lasts exactly 6 ticks (T_GREEN_MAX), then yellow.
//   - req_ew_i at tick 1 with req_ns_i=0 -> green yields exactly at tick 3 (T_GREEN_MIN), not before.
//   - maint_i asserted mid NS_YELLOW -> next clk both 11, en_o=1; on release -> ALLRED_INIT 1 tick -> NS_GREEN; pend_ew from before MAINT still served.
//   - rst_i pulse during EW_GREEN with tick_i same cycle -> outputs 11/11, timer 0, pend bits 0 next clk; every cycle check the no-conflicting-green invariant.

Source files
------------

// File: rtl/intersection_phase_sched_pkg.sv
// Shared light codes, phase encodings, default timing and the phase -> lights
// mapping used by the intersection phase scheduler.
package intersection_phase_sched_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;
    localparam logic [1:0] LIGHT_ALLRED = 2'b11;

    localparam int DEF_T_GREEN_MIN = 3;
    localparam int DEF_T_GREEN_MAX = 8;
    localparam int DEF_T_YELLOW    = 2;
    localparam int DEF_T_ALLRED    = 1;
    localparam int DEF_CW          = 4;

    typedef enum logic [2:0] {
        ST_ALLRED_INIT = 3'd0,
        ST_NS_GREEN    = 3'd1,
        ST_NS_YELLOW   = 3'd2,
        ST_ALLRED_A    = 3'd3,
        ST_EW_GREEN    = 3'd4,
        ST_EW_YELLOW   = 3'd5,
        ST_ALLRED_B    = 3'd6,
        ST_MAINT       = 3'd7
    } state_t;

    typedef struct packed {
        logic [1:0] w_ns;
        logic       tranzit_ns;
        logic [1:0] w_ew;
        logic       tranzit_ew;
    } lights_t;

    // Light codes and transit flags shown while the scheduler sits in st.
    function automatic lights_t lights_for(input state_t st);
        lights_t l;
        l.w_ns       = LIGHT_RED;
        l.tranzit_ns = 1'b0;
        l.w_ew       = LIGHT_RED;
        l.tranzit_ew = 1'b0;
        case (st)
            ST_NS_GREEN:  l.w_ns = LIGHT_GREEN;
            ST_NS_YELLOW: begin
                l.w_ns       = LIGHT_YELLOW;
                l.tranzit_ns = 1'b1;
            end
            ST_EW_GREEN:  l.w_ew = LIGHT_GREEN;
            ST_EW_YELLOW: begin
                l.w_ew       = LIGHT_YELLOW;
                l.tranzit_ew = 1'b1;
            end
            ST_ALLRED_INIT, ST_MAINT: begin
                l.w_ns = LIGHT_ALLRED;
                l.w_ew = LIGHT_ALLRED;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_phase_sched_timer.sv
// Phase timer: counts ticks since the last phase change, holding at its
// maximum value, and flags the tick on which the selected duration runs out.
module intersection_phase_sched_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          tick,
    input  logic [CW-1:0] dur,
    output logic [CW-1:0] count,
    output logic          expired
);

    localparam logic [CW-1:0] COUNT_MAX = '1;
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [CW-1:0] last;

    assign last = dur - ONE;

    // "At or past" rather than equality: a green that rested long enough to
    // saturate the counter must still yield on its maximum once the other
    // road asks, even if its own road keeps demanding.
    assign expired = tick && (count >= last);

    // Tick counter: cleared on every phase entry, saturates at COUNT_MAX.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only,
        // so every flop samples pre-edge values regardless of block ordering.
        if (rst || clear) begin
            count <= '0;
        end else if (tick && (count != COUNT_MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/intersection_phase_sched.sv
// Two-road intersection phase scheduler: sequences green -> yellow -> all-red
// per direction, arbitrates latched car-sensor demand, honours maintenance
// all-red, and drives registered light codes plus a load strobe.
module intersection_phase_sched
    import intersection_phase_sched_pkg::*;
#(
    parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
    parameter int T_GREEN_MAX = DEF_T_GREEN_MAX,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED,
    parameter int CW          = DEF_CW
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       req_ns_i,
    input  logic       req_ew_i,
    input  logic       maint_i,
    output logic [1:0] w_ns_o,
    output logic       tranzit_ns_o,
    output logic [1:0] w_ew_o,
    output logic       tranzit_ew_o,
    output logic       en_o,
    output logic [2:0] phase_o
);

    localparam logic [CW-1:0] GREEN_MIN_LAST = CW'(T_GREEN_MIN - 1);
    localparam logic [CW-1:0] DUR_GREEN      = CW'(T_GREEN_MAX);
    localparam logic [CW-1:0] DUR_YELLOW     = CW'(T_YELLOW);
    localparam logic [CW-1:0] DUR_ALLRED     = CW'(T_ALLRED);

    state_t        state;
    state_t        state_next;
    logic          pend_ns;
    logic          pend_ew;
    logic          want_ns;
    logic          want_ew;
    logic          phase_change;
    logic          timer_expired;
    logic [CW-1:0] timer;
    logic [CW-1:0] timer_dur;
    lights_t       lights_next;

    // A request seen this very cycle counts as demand immediately.
    assign want_ns      = pend_ns | req_ns_i;
    assign want_ew      = pend_ew | req_ew_i;
    assign phase_change = (state_next != state);

    intersection_phase_sched_timer #(
        .CW (CW)
    ) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (phase_change),
        .tick    (tick_i),
        .dur     (timer_dur),
        .count   (timer),
        .expired (timer_expired)
    );

    // Duration the timer is compared against in the current phase.
    always_comb begin
        case (state)
            ST_NS_GREEN, ST_EW_GREEN:   timer_dur = DUR_GREEN;
            ST_NS_YELLOW, ST_EW_YELLOW: timer_dur = DUR_YELLOW;
            default:                    timer_dur = DUR_ALLRED;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_ALLRED_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; maintenance overrides every timed transition.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch forms.
        state_next = state;
        if (maint_i) begin
            state_next = ST_MAINT;
        end else begin
            case (state)
                ST_ALLRED_INIT: if (timer_expired) state_next = ST_NS_GREEN;
                ST_NS_GREEN:
                    if (tick_i && want_ew &&
                        (((timer >= GREEN_MIN_LAST) && !req_ns_i) || timer_expired))
                        state_next = ST_NS_YELLOW;
                ST_NS_YELLOW:   if (timer_expired) state_next = ST_ALLRED_A;
                ST_ALLRED_A:    if (timer_expired) state_next = ST_EW_GREEN;
                ST_EW_GREEN:
                    if (tick_i && want_ns &&
                        (((timer >= GREEN_MIN_LAST) && !req_ew_i) || timer_expired))
                        state_next = ST_EW_YELLOW;
                ST_EW_YELLOW:   if (timer_expired) state_next = ST_ALLRED_B;
                ST_ALLRED_B:    if (timer_expired) state_next = ST_NS_GREEN;
                ST_MAINT:       state_next = ST_ALLRED_INIT;
                default:        state_next = ST_ALLRED_INIT;
            endcase
        end
    end

    // Pending demand: set while requested, cleared on entering that road's
    // green unless the request is still present (set wins).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_ns <= 1'b0;
            pend_ew <= 1'b0;
        end else begin
            pend_ns <= req_ns_i |
                       (pend_ns & ~(phase_change && (state_next == ST_NS_GREEN)));
            pend_ew <= req_ew_i |
                       (pend_ew & ~(phase_change && (state_next == ST_EW_GREEN)));
        end
    end

    // Output decode for the phase being entered.
    always_comb begin
        lights_next = lights_for(state_next);
    end

    // Output registers; en_o pulses for one cycle on every phase change and
    // is high out of reset so the controllers load all-red.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_ns_o       <= LIGHT_ALLRED;
            tranzit_ns_o <= 1'b0;
            w_ew_o       <= LIGHT_ALLRED;
            tranzit_ew_o <= 1'b0;
            en_o         <= 1'b1;
            phase_o      <= ST_ALLRED_INIT;
        end else begin
            w_ns_o       <= lights_next.w_ns;
            tranzit_ns_o <= lights_next.tranzit_ns;
            w_ew_o       <= lights_next.w_ew;
            tranzit_ew_o <= lights_next.tranzit_ew;
            en_o         <= phase_change;
            phase_o      <= state_next;
        end
    end

endmodule

// File: tb/tb_intersection_phase_sched.sv
// Self-checking bench for intersection_phase_sched: a directed vector table,
// hand-written multi-cycle sequences and randomized stimulus, all compared
// against a road/stage reference model kept here.
module tb_intersection_phase_sched;

    localparam int T_GREEN_MIN = 3;
    localparam int T_GREEN_MAX = 6;
    localparam int T_YELLOW    = 2;
    localparam int T_ALLRED    = 1;
    localparam int CW          = 4;
    localparam int NVEC        = 19;

    // in  = {rst, tick, req_ns, req_ew, maint}
    // exp = {w_ns, tranzit_ns, w_ew, tranzit_ew, en, phase}
    typedef struct packed {
        logic [4:0] in;
        logic [9:0] exp;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tick_i;
    logic       req_ns_i;
    logic       req_ew_i;
    logic       maint_i;
    logic [1:0] w_ns_o;
    logic       tranzit_ns_o;
    logic [1:0] w_ew_o;
    logic       tranzit_ew_o;
    logic       en_o;
    logic [2:0] phase_o;

    int checks   = 0;
    int failures = 0;
    int en_seen  = 0;

    // Reference model: mode 0 = initial clearance, 1 = serving roads, 2 = maintenance.
    // While serving, m_dir is the road holding right of way (0 NS, 1 EW) and
    // m_stage is 0 green, 1 yellow, 2 red clearance. m_ticks is unbounded.
    int  m_mode;
    int  m_dir;
    int  m_stage;
    int  m_ticks;
    bit  m_pend [2];
    bit  m_en;

    logic [1:0] prev_w_ns;
    logic [1:0] prev_w_ew;

    vec_t vecs [NVEC];

    intersection_phase_sched #(
        .T_GREEN_MIN (T_GREEN_MIN),
        .T_GREEN_MAX (T_GREEN_MAX),
        .T_YELLOW    (T_YELLOW),
        .T_ALLRED    (T_ALLRED),
        .CW          (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tick_i       (tick_i),
        .req_ns_i     (req_ns_i),
        .req_ew_i     (req_ew_i),
        .maint_i      (maint_i),
        .w_ns_o       (w_ns_o),
        .tranzit_ns_o (tranzit_ns_o),
        .w_ew_o       (w_ew_o),
        .tranzit_ew_o (tranzit_ew_o),
        .en_o         (en_o),
        .phase_o      (phase_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [9:0] dut_vec();
        return {w_ns_o, tranzit_ns_o, w_ew_o, tranzit_ew_o, en_o, phase_o};
    endfunction

    function automatic logic [1:0] m_light(input int d);
        if (m_mode != 1) return 2'b11;
        if (d != m_dir) return 2'b00;
        case (m_stage)
            0:       return 2'b10;
            1:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic m_transit(input int d);
        return (m_mode == 1) && (m_dir == d) && (m_stage == 1);
    endfunction

    function automatic int m_code();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 7;
        return 1 + 3 * m_dir + m_stage;
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_light(0), m_transit(0), m_light(1), m_transit(1), m_en, 3'(m_code())};
    endfunction

    function automatic logic is_go(input logic [1:0] w);
        return (w == 2'b10) || (w == 2'b01);
    endfunction

    // Advance the model across one clock edge with the inputs held during that cycle.
    task automatic model_edge(input bit r, input bit t, input bit rn, input bit re, input bit m);
        bit req [2];
        int elapsed;
        int opp;
        bit moved;
        req[0]  = rn;
        req[1]  = re;
        moved   = 1'b0;
        elapsed = m_ticks + (t ? 1 : 0);
        opp     = 1 - m_dir;
        if (r) begin
            m_mode    = 0;
            m_dir     = 0;
            m_stage   = 0;
            m_ticks   = 0;
            m_pend[0] = 1'b0;
            m_pend[1] = 1'b0;
            m_en      = 1'b1;
            return;
        end
        if (m) begin
            if (m_mode != 2) begin
                m_mode = 2;
                moved  = 1'b1;
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
            moved  = 1'b1;
        end else if (m_mode == 0) begin
            if (t && elapsed >= T_ALLRED) begin
                m_mode  = 1;
                m_dir   = 0;
                m_stage = 0;
                moved   = 1'b1;
            end
        end else if (m_stage == 0) begin
            if (t && (m_pend[opp] || req[opp]) &&
                ((elapsed >= T_GREEN_MIN && !req[m_dir]) || elapsed >= T_GREEN_MAX)) begin
                m_stage = 1;
                moved   = 1'b1;
            end
        end else if (m_stage == 1) begin
            if (t && elapsed >= T_YELLOW) begin
                m_stage = 2;
                moved   = 1'b1;
            end
        end else begin
            if (t && elapsed >= T_ALLRED) begin
                m_dir   = opp;
                m_stage = 0;
                moved   = 1'b1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (moved && m_mode == 1 && m_stage == 0 && m_dir == d) m_pend[d] = req[d];
            else m_pend[d] = m_pend[d] | req[d];
        end
        m_ticks = moved ? 0 : elapsed;
        m_en    = moved;
    endtask

    // One clock cycle: drive inputs, let the edge pass, compare against the
    // model and check the safety invariants.
    task automatic step(input bit r, input bit t, input bit rn, input bit re, input bit m);
        logic conflict;
        logic skipped;
        rst_i    = r;
        tick_i   = t;
        req_ns_i = rn;
        req_ew_i = re;
        maint_i  = m;
        @(posedge clk_i);
        model_edge(r, t, rn, re, m);
        #1;
        check("model_outputs", {22'd0, dut_vec()}, {22'd0, model_vec()});
        conflict = is_go(w_ns_o) && is_go(w_ew_o);
        skipped  = (prev_w_ns == 2'b10 && w_ns_o == 2'b00) ||
                   (prev_w_ew == 2'b10 && w_ew_o == 2'b00);
        check("invariant", {30'd0, conflict, skipped}, 32'd0);
        prev_w_ns = w_ns_o;
        prev_w_ew = w_ew_o;
        if (en_o) en_seen++;
    endtask

    // One timebase period of 4 clocks with the tick in the last one.
    task automatic tick4(input bit rn, input bit re_idle, input bit re_tick, input bit m);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rn, re_idle, m);
        step(1'b0, 1'b1, rn, re_tick, m);
    endtask

    initial begin
        int n;
        int en_before;
        bit rn;
        bit re;
        bit mt;

        rst_i     = 1'b1;
        tick_i    = 1'b0;
        req_ns_i  = 1'b0;
        req_ew_i  = 1'b0;
        maint_i   = 1'b0;
        prev_w_ns = 2'b11;
        prev_w_ew = 2'b11;
        m_mode    = 0;
        m_dir     = 0;
        m_stage   = 0;
        m_ticks   = 0;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        m_en      = 1'b1;

        // Directed vectors, one clock per row.
        vecs[0]  = '{in: 5'b10000, exp: 10'b11_0_11_0_1_000};
        vecs[1]  = '{in: 5'b00000, exp: 10'b11_0_11_0_0_000};
        vecs[2]  = '{in: 5'b01000, exp: 10'b10_0_00_0_1_001};
        vecs[3]  = '{in: 5'b00000, exp: 10'b10_0_00_0_0_001};
        vecs[4]  = '{in: 5'b01010, exp: 10'b10_0_00_0_0_001};
        vecs[5]  = '{in: 5'b01000, exp: 10'b10_0_00_0_0_001};
        vecs[6]  = '{in: 5'b01000, exp: 10'b01_1_00_0_1_010};
        vecs[7]  = '{in: 5'b01000, exp: 10'b01_1_00_0_0_010};
        vecs[8]  = '{in: 5'b01000, exp: 10'b00_0_00_0_1_011};
        vecs[9]  = '{in: 5'b01000, exp: 10'b00_0_10_0_1_100};
        vecs[10] = '{in: 5'b01100, exp: 10'b00_0_10_0_0_100};
        vecs[11] = '{in: 5'b00000, exp: 10'b00_0_10_0_0_100};
        vecs[12] = '{in: 5'b01000, exp: 10'b00_0_10_0_0_100};
        vecs[13] = '{in: 5'b01000, exp: 10'b00_0_01_1_1_101};
        vecs[14] = '{in: 5'b00001, exp: 10'b11_0_11_0_1_111};
        vecs[15] = '{in: 5'b00001, exp: 10'b11_0_11_0_0_111};
        vecs[16] = '{in: 5'b00000, exp: 10'b11_0_11_0_1_000};
        vecs[17] = '{in: 5'b01000, exp: 10'b10_0_00_0_1_001};
        vecs[18] = '{in: 5'b01000, exp: 10'b10_0_00_0_0_001};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
            check($sformatf("vec%0d", i), {22'd0, dut_vec()}, {22'd0, vecs[i].exp});
        end

        // NS green with no opposing demand rests for 20 ticks without a phase change.
        en_before = en_seen;
        for (int i = 0; i < 20; i++) tick4(1'b0, 1'b0, 1'b0, 1'b0);
        check("rest_en_pulses", en_seen - en_before, 0);
        check("rest_phase", {29'd0, phase_o}, 32'd1);
        check("rest_w_ns", {30'd0, w_ns_o}, 32'd2);
        // A long-rested (saturated) green still yields to a new opposing request.
        tick4(1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_yield_phase", {29'd0, phase_o}, 32'd2);

        // req_ew pulse on tick 5 of NS green, req_ns low.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick4(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick4(1'b0, 1'b0, 1'b0, 1'b0);
        tick4(1'b0, 1'b0, 1'b1, 1'b0);
        check("pulse_yellow", {29'd0, phase_o}, 32'd2);
        check("pulse_tranzit_ns", {31'd0, tranzit_ns_o}, 32'd1);
        tick4(1'b0, 1'b0, 1'b0, 1'b0);
        check("yellow_after_1", {29'd0, phase_o}, 32'd2);
        tick4(1'b0, 1'b0, 1'b0, 1'b0);
        check("allred_a", {29'd0, phase_o}, 32'd3);
        tick4(1'b0, 1'b0, 1'b0, 1'b0);
        check("ew_green", {29'd0, phase_o}, 32'd4);
        check("pend_ew_cleared", {31'd0, dut.pend_ew}, 32'd0);

        // Both roads demanding from green entry: green lasts T_GREEN_MAX ticks.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick4(1'b1, 1'b1, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick4(1'b1, 1'b1, 1'b1, 1'b0);
            n++;
            if (phase_o != 3'd1) break;
        end
        check("max_green_ticks", n, 6);
        check("max_green_next", {29'd0, phase_o}, 32'd2);

        // req_ew on tick 1 only, req_ns low: yields at tick T_GREEN_MIN.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick4(1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick4(1'b0, 1'b0, (i == 0), 1'b0);
            n++;
            if (phase_o != 3'd1) break;
        end
        check("min_green_ticks", n, 3);

        // Maintenance mid NS yellow, then release; the earlier EW demand is served.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("maint_entry", {22'd0, dut_vec()}, {22'd0, 10'b11_0_11_0_1_111});
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("maint_release", {22'd0, dut_vec()}, {22'd0, 10'b11_0_11_0_1_000});
        tick4(1'b0, 1'b0, 1'b0, 1'b0);
        check("maint_ns_green", {29'd0, phase_o}, 32'd1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick4(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
            if (phase_o != 3'd1) break;
        end
        check("maint_pend_served", n, 3);
        for (int i = 0; i < 3; i++) tick4(1'b0, 1'b0, 1'b0, 1'b0);
        check("maint_ew_green", {29'd0, phase_o}, 32'd4);

        // Reset during EW green with a tick in the same cycle.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_outputs", {22'd0, dut_vec()}, {22'd0, 10'b11_0_11_0_1_000});
        check("rst_timer", {28'd0, dut.timer}, 32'd0);
        check("rst_pend", {30'd0, dut.pend_ns, dut.pend_ew}, 32'd0);

        // Randomized traffic against the model.
        rn = 1'b0;
        re = 1'b0;
        mt = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            bit r;
            bit t;
            r = ($urandom_range(0, 699) == 0);
            t = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) rn = ~rn;
            if ($urandom_range(0, 15) == 0) re = ~re;
            if (mt) mt = ($urandom_range(0, 7) != 0);
            else    mt = ($urandom_range(0, 299) == 0);
            step(r, t, rn, re, mt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
